// File: rtl/mult_unit.sv
// mult_unit: sequential 32x32->64 shift-add multiplier with architectural HI/LO.
// Handles mult/multu (33-cycle latency), mthi/mtlo writes, and supplies hi/lo.
module mult_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_mcand_in;
    logic [31:0] w_mplier_in;
    logic [32:0] w_sum;
    logic [63:0] w_acc_shift;
    logic [63:0] w_prod;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN:  if (r_cnt == 5'd31) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes, one shift-add iteration, and sign-corrected product
    always_comb begin
        w_mcand_in  = (is_signed && a[31]) ? (~a + 32'd1) : a;
        w_mplier_in = (is_signed && b[31]) ? (~b + 32'd1) : b;
        w_sum       = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
        // The carry out of the upper-half add becomes bit 63 after the shift
        w_acc_shift = {w_sum, r_acc[31:1]};
        w_prod      = r_neg ? (~r_acc + 64'd1) : r_acc;
    end

    // Working registers, HI/LO architectural registers and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_neg    <= is_signed & (a[31] ^ b[31]);
                        r_mcand  <= w_mcand_in;
                        r_mplier <= w_mplier_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        if (wr_hi) r_hi <= wdata;
                        if (wr_lo) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_shift;
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    r_hi   <= w_prod[63:32];
                    r_lo   <= w_prod[31:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed self-checking bench for mult_unit.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side model of the architectural HI/LO contents
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // One multiply from start edge E0 through E34; optional start/wr pulse at cycle inj
    task automatic run_mult(input string name, input logic [31:0] ia, input logic [31:0] ib,
                            input logic s, input logic [63:0] prod, input int inj);
        logic bad;
        a = ia; b = ib; is_signed = s; start = 1'b1;
        @(posedge clk); #1;  // E0
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        a = ~ia; b = ~ib; is_signed = ~s;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_E0: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        end
        bad = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) bad = 1'b1;
            if (k == inj) begin
                start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
                a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            end
        end
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s_run: busy/done/hold wrong during E1..E32, last busy=%b done=%b hi=%h lo=%h, required busy=1 done=0 hi=%h lo=%h",
                     name, busy, done, hi, lo, m_hi, m_lo);
        end
        @(posedge clk); #1;  // E33
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== prod[63:32] || lo !== prod[31:0]) begin
            n_fail++;
            $display("FAIL %s_E33: busy=%b done=%b hi=%h lo=%h, required busy=0 done=1 hi=%h lo=%h",
                     name, busy, done, hi, lo, prod[63:32], prod[31:0]);
        end
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        @(posedge clk); #1;  // E34
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s_E34: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h",
                     name, busy, done, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 00000000 00000000", busy, done, hi, lo);
        end
    endtask

    task automatic test_unsigned();
        run_mult("u7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0);
        run_mult("uFFxFF", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 0);
    endtask

    task automatic test_signed();
        run_mult("s-3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 0);
        run_mult("sFFxFF", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 0);
        run_mult("s8x8", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 0);
        run_mult("s8x1", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000, 0);
    endtask

    task automatic test_hilo_write();
        wr_hi = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        m_hi = 32'hAAAA5555;
        n_tests++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL mthi_only: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h12345678;
        @(posedge clk);
        #1 wr_lo = 1'b0; wr_hi = 1'b0;
        wr_lo = 1'b1; wdata = 32'h9ABCDEF0;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
        n_tests++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        n_tests++;
        if (hi !== 32'h0BADF00D || lo !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL mthi_mtlo_same: hi=%h lo=%h, required 0badf00d 0badf00d", hi, lo);
        end
        wr_hi = 1'b1; wdata = 32'h12345678;
        @(posedge clk); #1;
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h9ABCDEF0;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
        n_tests++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL hilo_restore: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_busy_ignore();
        // writes requested alongside start must be dropped, and the pulse at cycle 10 ignored
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFEF00D;
        run_mult("busy_ign", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 10);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ign_nostart: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, required 0 0 00000000 00000000", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_no_done: done/busy seen after abort (done=%b busy=%b), required 0", done, busy);
        end
        run_mult("after_rst", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0);
    endtask

    task automatic test_back_to_back();
        a = 32'd2; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b hi=%h lo=%h, required 1 00000000 00000006", done, hi, lo);
        end
        a = 32'd4; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
        end
        repeat (33) @(posedge clk);
        #1;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd20) begin
            n_fail++;
            $display("FAIL b2b_second: busy=%b done=%b hi=%h lo=%h, required 0 1 00000000 00000014", busy, done, hi, lo);
        end
        m_hi = 32'h0; m_lo = 32'd20;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_hilo_write();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
